// File: rtl/hazard_scoreboard.sv
// Producer-side hazard scoreboard for the five-stage MIPS pipeline.
// Tracks in-flight GPR writes in EX/MEM/WB plus mult/div busy time and raises stall for IF/ID.
module hazard_scoreboard #(
    parameter int unsigned MD_LAT = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_rs_used,
    input  logic       id_rt_used,
    input  logic [1:0] id_rs_tuse,
    input  logic [1:0] id_rt_tuse,
    input  logic       id_wr_en,
    input  logic [4:0] id_wr_addr,
    input  logic [1:0] id_tnew,
    input  logic       id_md_start,
    input  logic       id_md_use,
    input  logic       flush,
    output logic       stall,
    output logic       md_busy,
    output logic [3:0] md_count
);

    typedef struct packed {
        logic       v;
        logic [4:0] addr;
        logic [1:0] tnew;
    } slot_t;

    slot_t      r_ex, r_mem, r_wb;
    logic [3:0] r_md_count;
    logic       w_rs_haz, w_rt_haz, w_md_haz, w_md_load;
    slot_t      w_ex_next;

    function automatic logic [1:0] sat_dec(input logic [1:0] x);
        return (x == 2'd0) ? 2'd0 : x - 2'd1;
    endfunction

    // Youngest matching producer governs: EX beats MEM beats WB.
    function automatic logic src_hazard(
        input logic       valid,
        input logic       used,
        input logic [4:0] src,
        input logic [1:0] tuse,
        input slot_t      ex,
        input slot_t      mem,
        input slot_t      wb
    );
        logic       hit;
        logic [1:0] tnew;
        hit  = 1'b0;
        tnew = 2'd0;
        if (ex.v && ex.addr == src) begin
            hit  = 1'b1;
            tnew = ex.tnew;
        end else if (mem.v && mem.addr == src) begin
            hit  = 1'b1;
            tnew = mem.tnew;
        end else if (wb.v && wb.addr == src) begin
            hit  = 1'b1;
            tnew = wb.tnew;
        end
        return valid && used && (src != 5'd0) && hit && (tnew > tuse);
    endfunction

    always_comb begin
        w_rs_haz  = src_hazard(id_valid, id_rs_used, id_rs, id_rs_tuse, r_ex, r_mem, r_wb);
        w_rt_haz  = src_hazard(id_valid, id_rt_used, id_rt, id_rt_tuse, r_ex, r_mem, r_wb);
        w_md_haz  = id_valid && id_md_use && (r_md_count != 4'd0);
        w_md_load = id_valid && id_md_start && !stall && !flush;

        w_ex_next      = '0;
        w_ex_next.v    = id_valid && id_wr_en && (id_wr_addr != 5'd0);
        w_ex_next.addr = id_wr_addr;
        w_ex_next.tnew = id_tnew;
    end

    assign stall    = w_rs_haz || w_rt_haz || w_md_haz;
    assign md_busy  = (r_md_count != 4'd0);
    assign md_count = r_md_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ex  <= '0;
            r_mem <= '0;
            r_wb  <= '0;
        end else if (flush) begin
            r_ex  <= '0;
            r_mem <= '0;
            r_wb  <= '0;
        end else begin
            r_ex       <= stall ? '0 : w_ex_next;
            r_mem.v    <= r_ex.v;
            r_mem.addr <= r_ex.addr;
            r_mem.tnew <= sat_dec(r_ex.tnew);
            r_wb.v     <= r_mem.v;
            r_wb.addr  <= r_mem.addr;
            r_wb.tnew  <= sat_dec(r_mem.tnew);
        end
    end

    // The arithmetic unit cannot be cancelled, so flush leaves the counter alone.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_md_count <= '0;
        end else if (w_md_load) begin
            r_md_count <= 4'(MD_LAT);
        end else if (r_md_count != 4'd0) begin
            r_md_count <= r_md_count - 4'd1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Table-driven check of hazard_scoreboard: sequential vectors with hand-computed
// stall/md outputs, plus flush and mid-operation reset sequences.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid, id_rs_used, id_rt_used, id_wr_en, id_md_start, id_md_use, flush;
    logic [4:0] id_rs, id_rt, id_wr_addr;
    logic [1:0] id_rs_tuse, id_rt_tuse, id_tnew;
    logic       stall, md_busy;
    logic [3:0] md_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.MD_LAT(5)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_rs_tuse(id_rs_tuse), .id_rt_tuse(id_rt_tuse), .id_wr_en(id_wr_en),
        .id_wr_addr(id_wr_addr), .id_tnew(id_tnew), .id_md_start(id_md_start),
        .id_md_use(id_md_use), .flush(flush), .stall(stall), .md_busy(md_busy),
        .md_count(md_count)
    );

    typedef struct {
        logic       valid;
        logic [4:0] rs;
        logic       rsu;
        logic [1:0] rstu;
        logic [4:0] rt;
        logic       rtu;
        logic [1:0] rttu;
        logic       we;
        logic [4:0] wa;
        logic [1:0] tn;
        logic       ms;
        logic       mu;
        logic       fl;
        logic       es;
        logic       eb;
        logic [3:0] ec;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int valid, int rs, int rsu, int rstu, int rt, int rtu, int rttu,
                                int we, int wa, int tn, int ms, int mu, int fl,
                                int es, int eb, int ec);
        vec_t v;
        v.valid = 1'(valid); v.rs = 5'(rs); v.rsu = 1'(rsu); v.rstu = 2'(rstu);
        v.rt = 5'(rt); v.rtu = 1'(rtu); v.rttu = 2'(rttu);
        v.we = 1'(we); v.wa = 5'(wa); v.tn = 2'(tn);
        v.ms = 1'(ms); v.mu = 1'(mu); v.fl = 1'(fl);
        v.es = 1'(es); v.eb = 1'(eb); v.ec = 4'(ec);
        return v;
    endfunction

    task automatic drive(input vec_t v);
        id_valid = v.valid; id_rs = v.rs; id_rs_used = v.rsu; id_rs_tuse = v.rstu;
        id_rt = v.rt; id_rt_used = v.rtu; id_rt_tuse = v.rttu;
        id_wr_en = v.we; id_wr_addr = v.wa; id_tnew = v.tn;
        id_md_start = v.ms; id_md_use = v.mu; flush = v.fl;
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic es, input logic eb, input logic [3:0] ec);
        check({tag, ".stall"}, {3'd0, stall}, {3'd0, es});
        check({tag, ".md_busy"}, {3'd0, md_busy}, {3'd0, eb});
        check({tag, ".md_count"}, md_count, ec);
    endtask

    initial begin
        //            vl rs u tu rt u tu we wa tn ms mu fl  es eb ec
        // lw $8 -> addu $8 : one stall
        tbl.push_back(mk(1, 9,1,1, 0,0,0, 1, 8,2, 0,0,0, 0,0,0));
        tbl.push_back(mk(1, 8,1,1, 0,0,0, 1,10,1, 0,0,0, 1,0,0));
        tbl.push_back(mk(1, 8,1,1, 0,0,0, 1,10,1, 0,0,0, 0,0,0));
        tbl.push_back(mk(0, 0,0,0, 0,0,0, 0, 0,0, 0,0,0, 0,0,0));
        tbl.push_back(mk(0, 0,0,0, 0,0,0, 0, 0,0, 0,0,0, 0,0,0));
        tbl.push_back(mk(0, 0,0,0, 0,0,0, 0, 0,0, 0,0,0, 0,0,0));
        // lw $8 -> beq $8 : two stalls
        tbl.push_back(mk(1, 0,0,0, 0,0,0, 1, 8,2, 0,0,0, 0,0,0));
        tbl.push_back(mk(1, 8,1,0, 0,1,0, 0, 0,0, 0,0,0, 1,0,0));
        tbl.push_back(mk(1, 8,1,0, 0,1,0, 0, 0,0, 0,0,0, 1,0,0));
        tbl.push_back(mk(1, 8,1,0, 0,1,0, 0, 0,0, 0,0,0, 0,0,0));
        // lw $8 -> sw data $8 : none; addu $9 -> beq $9 : one
        tbl.push_back(mk(1, 0,0,0, 0,0,0, 1, 8,2, 0,0,0, 0,0,0));
        tbl.push_back(mk(1,29,1,1, 8,1,2, 0, 0,0, 0,0,0, 0,0,0));
        tbl.push_back(mk(1, 0,0,0, 0,0,0, 1, 9,1, 0,0,0, 0,0,0));
        tbl.push_back(mk(1, 9,1,0, 8,1,0, 0, 0,0, 0,0,0, 1,0,0));
        tbl.push_back(mk(1, 9,1,0, 8,1,0, 0, 0,0, 0,0,0, 0,0,0));
        // addu $8 then lw $8: youngest (load in EX) governs
        tbl.push_back(mk(1, 0,0,0, 0,0,0, 1, 8,1, 0,0,0, 0,0,0));
        tbl.push_back(mk(1, 0,0,0, 0,0,0, 1, 8,2, 0,0,0, 0,0,0));
        tbl.push_back(mk(1, 8,1,1, 0,0,0, 0, 0,0, 0,0,0, 1,0,0));
        tbl.push_back(mk(1, 8,1,1, 0,0,0, 0, 0,0, 0,0,0, 0,0,0));
        // write to $0 and reads of $0 never stall
        tbl.push_back(mk(1, 0,0,0, 0,0,0, 1, 0,2, 0,0,0, 0,0,0));
        tbl.push_back(mk(1, 0,1,0, 0,1,0, 0, 0,0, 0,0,0, 0,0,0));
        // invalid ID never stalls; later real consumer does
        tbl.push_back(mk(1, 0,0,0, 0,0,0, 1, 8,2, 0,0,0, 0,0,0));
        tbl.push_back(mk(0, 8,1,0, 8,1,0, 1, 8,2, 1,1,0, 0,0,0));
        tbl.push_back(mk(1, 8,1,0, 0,0,0, 0, 0,0, 0,0,0, 1,0,0));
        tbl.push_back(mk(1, 8,1,0, 0,0,0, 0, 0,0, 0,0,0, 0,0,0));
        // mult then mflo: 5 stall cycles, issue on the 6th
        tbl.push_back(mk(1, 0,0,0, 0,0,0, 0, 0,0, 1,1,0, 0,0,0));
        tbl.push_back(mk(1, 0,0,0, 0,0,0, 1, 8,1, 0,1,0, 1,1,5));
        tbl.push_back(mk(1, 0,0,0, 0,0,0, 1, 8,1, 0,1,0, 1,1,4));
        tbl.push_back(mk(1, 0,0,0, 0,0,0, 1, 8,1, 0,1,0, 1,1,3));
        tbl.push_back(mk(1, 0,0,0, 0,0,0, 1, 8,1, 0,1,0, 1,1,2));
        tbl.push_back(mk(1, 0,0,0, 0,0,0, 1, 8,1, 0,1,0, 1,1,1));
        tbl.push_back(mk(1, 0,0,0, 0,0,0, 1, 8,1, 0,1,0, 0,0,0));
        // md_start while busy is stalled and does not reload
        tbl.push_back(mk(1, 0,0,0, 0,0,0, 0, 0,0, 1,1,0, 0,0,0));
        tbl.push_back(mk(1, 0,0,0, 0,0,0, 0, 0,0, 1,1,0, 1,1,5));
        tbl.push_back(mk(0, 0,0,0, 0,0,0, 0, 0,0, 0,0,0, 0,1,4));
        tbl.push_back(mk(0, 0,0,0, 0,0,0, 0, 0,0, 0,0,0, 0,1,3));
        tbl.push_back(mk(0, 0,0,0, 0,0,0, 0, 0,0, 0,0,0, 0,1,2));
        tbl.push_back(mk(0, 0,0,0, 0,0,0, 0, 0,0, 0,0,0, 0,1,1));
        tbl.push_back(mk(0, 0,0,0, 0,0,0, 0, 0,0, 0,0,0, 0,0,0));

        // Reset with a live consumer in ID
        reset = 1'b0;
        drive(mk(1, 8,1,0, 0,0,0, 1, 8,2, 0,0,0, 0,0,0));
        #2;
        check_all("reset", 1'b0, 1'b0, 4'd0);
        @(negedge clk);
        reset = 1'b1;
        drive(mk(0, 0,0,0, 0,0,0, 0, 0,0, 0,0,0, 0,0,0));
        @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            @(negedge clk);
            check_all($sformatf("v%0d", i), tbl[i].es, tbl[i].eb, tbl[i].ec);
            @(posedge clk);
            #1;
        end

        // flush with a matching hazard; md counter keeps running
        drive(mk(1, 0,0,0, 0,0,0, 0, 0,0, 1,1,0, 0,0,0));
        @(negedge clk); check_all("fl0", 1'b0, 1'b0, 4'd0);
        @(posedge clk); #1;
        drive(mk(1, 0,0,0, 0,0,0, 1, 8,2, 0,0,0, 0,0,0));
        @(negedge clk); check_all("fl1", 1'b0, 1'b1, 4'd5);
        @(posedge clk); #1;
        drive(mk(1, 8,1,1, 0,0,0, 0, 0,0, 0,0,1, 0,0,0));
        @(negedge clk); check_all("fl2", 1'b1, 1'b1, 4'd4);
        @(posedge clk); #1;
        drive(mk(1, 8,1,1, 0,0,0, 0, 0,0, 0,0,0, 0,0,0));
        @(negedge clk); check_all("fl3", 1'b0, 1'b1, 4'd3);
        @(posedge clk); #1;
        drive(mk(0, 0,0,0, 0,0,0, 0, 0,0, 0,0,0, 0,0,0));
        repeat (4) @(posedge clk);
        #1;

        // asynchronous reset mid-operation
        drive(mk(1, 0,0,0, 0,0,0, 0, 0,0, 1,1,0, 0,0,0));
        @(posedge clk); #1;
        drive(mk(1, 0,0,0, 0,0,0, 1, 8,2, 0,0,0, 0,0,0));
        @(posedge clk); #1;
        drive(mk(1, 8,1,1, 0,0,0, 0, 0,0, 0,0,0, 0,0,0));
        #1;
        check_all("rst_pre", 1'b1, 1'b1, 4'd4);
        reset = 1'b0;
        #1;
        check_all("rst_mid", 1'b0, 1'b0, 4'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_all("rst_rel", 1'b0, 1'b0, 4'd0);
        @(posedge clk); #1;
        check_all("rst_post", 1'b0, 1'b0, 4'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
